// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side consumer of a dual-clock byte FIFO. It runs entirely in the FIFO
//   read-clock domain. It waits until the FIFO holds a full burst and there is
//   room for that burst in the output buffer. It then issues a fixed-length
//   rd_en burst, packs the returned bytes little-endian into PACK-byte words,
//   and presents them on a valid/ready stream through a small word buffer with
//   a registered head.
//
// Ports
//   clk, rst_n           read-domain clock, asynchronous active-low reset
//   fifo_dout/valid      returned FIFO byte, valid one cycle after rd_en
//   fifo_empty           FIFO empty; gates rd_en combinationally
//   fifo_underflow       FIFO underflow pulse -> sticky err_underflow
//   fifo_rd_data_count   conservative FIFO occupancy used to start a burst
//   fifo_rd_rst_busy     FIFO read-side reset; aborts a running burst
//   fifo_rd_en           FIFO read enable
//   m_data/valid/ready   packed output stream, first byte in the low lane
//   m_last               last word of a completed burst
//   busy                 high while not in IDLE
//   burst_done_cnt       completed bursts, wraps at 16'hFFFF
//   err_underflow/abort  sticky error flags, cleared only by reset
module fifo_burst_reader #(
  parameter int DATA_W     = 8,
  parameter int PACK       = 4,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 8,
  parameter int OBUF_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      fifo_dout,
  input  logic                   fifo_valid,
  input  logic                   fifo_empty,
  input  logic                   fifo_underflow,
  input  logic [CNT_W-1:0]       fifo_rd_data_count,
  input  logic                   fifo_rd_rst_busy,
  output logic                   fifo_rd_en,
  output logic [DATA_W*PACK-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic [15:0]            burst_done_cnt,
  output logic                   err_underflow,
  output logic                   err_abort
);

  localparam int WW    = DATA_W * PACK;
  localparam int CW    = $clog2(BURST_LEN + 1);
  localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int OW    = $clog2(OBUF_DEPTH + 1);
  localparam int PW    = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int WORDS = BURST_LEN / PACK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_issue_cnt;
  logic [CW-1:0]   r_rx_cnt;
  logic [LW-1:0]   r_lane;
  logic [WW-1:0]   r_pack;
  logic [WW:0]     r_mem [OBUF_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [OW-1:0]   r_mem_cnt;
  logic [WW-1:0]   r_m_data;
  logic            r_m_valid;
  logic            r_m_last;
  logic [15:0]     r_done_cnt;
  logic            r_err_uf;
  logic            r_err_ab;

  logic            w_active;
  logic            w_abort;
  logic            w_rd_en;
  logic            w_rx_byte;
  logic            w_push;
  logic            w_push_last;
  logic [WW-1:0]   w_word;
  logic [OW-1:0]   w_occ;
  logic            w_room;
  logic            w_burst_end;
  logic            w_pop;
  logic            w_load_head;
  logic            w_mem_rd;
  logic            w_bypass;
  logic            w_mem_wr;

  // Datapath qualifiers. rd_rst_busy gates rd_en and byte capture in the same cycle.
  always_comb begin
    w_active    = (r_state != ST_IDLE);
    w_abort     = w_active && fifo_rd_rst_busy;
    w_rd_en     = (r_state == ST_READ) && !fifo_empty && !fifo_rd_rst_busy;
    w_rx_byte   = w_active && fifo_valid && !fifo_rd_rst_busy;
    w_push      = w_rx_byte && (r_lane == LW'(PACK - 1));
    w_push_last = (r_rx_cnt == CW'(BURST_LEN - 1));
    // Occupancy counts the head register too, so a burst starts only if the
    // whole burst fits.
    w_occ       = r_mem_cnt + {{(OW-1){1'b0}}, r_m_valid};
    w_room      = (w_occ <= OW'(OBUF_DEPTH - WORDS));
    w_burst_end = (r_state == ST_DRAIN) && (r_rx_cnt == CW'(BURST_LEN)) && !fifo_rd_rst_busy;
    w_pop       = r_m_valid && m_ready;
    w_load_head = !r_m_valid || w_pop;
    w_mem_rd    = w_load_head && (r_mem_cnt != '0);
    // An empty buffer lets the completed word go straight into the head register.
    w_bypass    = w_load_head && (r_mem_cnt == '0) && w_push;
    w_mem_wr    = w_push && !w_bypass;
  end

  // Completed word: the bytes packed so far plus the byte arriving now in its lane.
  always_comb begin
    w_word = r_pack;
    w_word[int'(r_lane)*DATA_W +: DATA_W] = fifo_dout;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_rd_rst_busy && (fifo_rd_data_count >= CNT_W'(BURST_LEN)) && w_room) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (fifo_rd_rst_busy) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rd_en && (r_issue_cnt == CW'(BURST_LEN - 1))) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (fifo_rd_rst_busy || w_burst_end) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue/receive counters and byte packer. IDLE clears them, which also discards an aborted burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
    end else if (r_state == ST_IDLE) begin
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
    end else begin
      if (w_rd_en) begin
        r_issue_cnt <= r_issue_cnt + CW'(1);
      end
      if (w_rx_byte) begin
        r_pack[int'(r_lane)*DATA_W +: DATA_W] <= fifo_dout;
        r_rx_cnt <= r_rx_cnt + CW'(1);
        if (r_lane == LW'(PACK - 1)) begin
          r_lane <= '0;
        end else begin
          r_lane <= r_lane + LW'(1);
        end
      end
    end
  end

  // Output word buffer: storage array behind a registered head (m_data/m_valid/m_last).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_mem_wr) begin
        r_mem[r_wr_ptr] <= {w_push_last, w_word};
        r_wr_ptr <= (r_wr_ptr == PW'(OBUF_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_mem_rd) begin
        r_rd_ptr <= (r_rd_ptr == PW'(OBUF_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_mem_wr, w_mem_rd})
        2'b10:   r_mem_cnt <= r_mem_cnt + OW'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - OW'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      // Head reloads only when empty or being accepted, so it is stable under backpressure.
      if (w_load_head) begin
        if (w_mem_rd) begin
          {r_m_last, r_m_data} <= r_mem[r_rd_ptr];
          r_m_valid <= 1'b1;
        end else if (w_bypass) begin
          r_m_data  <= w_word;
          r_m_last  <= w_push_last;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      end
    end
  end

  // Completed-burst counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
      r_err_uf   <= 1'b0;
      r_err_ab   <= 1'b0;
    end else begin
      if (w_burst_end) begin
        r_done_cnt <= r_done_cnt + 16'd1;
      end
      if (fifo_underflow) begin
        r_err_uf <= 1'b1;
      end
      if (w_abort) begin
        r_err_ab <= 1'b1;
      end
    end
  end

  assign fifo_rd_en     = w_rd_en;
  assign m_data         = r_m_data;
  assign m_valid        = r_m_valid;
  assign m_last         = r_m_last;
  assign busy           = (r_state != ST_IDLE);
  assign burst_done_cnt = r_done_cnt;
  assign err_underflow  = r_err_uf;
  assign err_abort      = r_err_ab;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader. A small behavioural byte FIFO feeds the
//   design, and a monitor records accepted output words and rd_en cycles. The
//   bench runs a table of single-burst vectors, then hand-written sequences for
//   a partial burst, backpressure, empty stalls, abort, underflow and
//   asynchronous reset.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [7:0]  fifo_rd_data_count;
  logic        fifo_rd_rst_busy;
  logic        fifo_rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [15:0] burst_done_cnt;
  logic        err_underflow;
  logic        err_abort;

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_dout          (fifo_dout),
    .fifo_valid         (fifo_valid),
    .fifo_empty         (fifo_empty),
    .fifo_underflow     (fifo_underflow),
    .fifo_rd_data_count (fifo_rd_data_count),
    .fifo_rd_rst_busy   (fifo_rd_rst_busy),
    .fifo_rd_en         (fifo_rd_en),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_last             (m_last),
    .busy               (busy),
    .burst_done_cnt     (burst_done_cnt),
    .err_underflow      (err_underflow),
    .err_abort          (err_abort)
  );

  logic [7:0]  fq[$];
  logic [32:0] got[$];
  int          rd_idx_q[$];
  logic        force_empty = 1'b0;
  logic        busy_seen = 1'b0;
  logic        rd_s;
  int          rd_total = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic [7:0]       base;
    logic [3:0][31:0] w;
  } vec_t;
  vec_t vecs [5];

  function automatic void refresh();
    fifo_rd_data_count = (fq.size() > 255) ? 8'hFF : 8'(fq.size());
    fifo_empty         = (fq.size() == 0) || force_empty;
  endfunction

  // Behavioural FIFO: rd_en seen at the edge returns a byte one cycle later; also the output monitor.
  always @(posedge clk) begin
    rd_s = fifo_rd_en;
    cyc  = cyc + 1;
    if (rd_s === 1'b1) begin
      rd_total = rd_total + 1;
      rd_idx_q.push_back(cyc);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) got.push_back({m_last, m_data});
    if (busy === 1'b1) busy_seen = 1'b1;
    #1;
    if (rd_s === 1'b1 && fq.size() > 0) begin
      fifo_dout  = fq.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = 1'b0;
    end
    refresh();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    refresh();
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("words_available", 64'(got.size()), 64'(n));
  endtask

  task automatic wait_reads(input int r0, input int n, input int budget);
    int k;
    k = 0;
    while ((rd_total - r0) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("reads_reached", 64'(rd_total - r0), 64'(n));
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic set_vec(input int i, input logic [7:0] base, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    vecs[i].base = base;
    vecs[i].w[0] = w0;
    vecs[i].w[1] = w1;
    vecs[i].w[2] = w2;
    vecs[i].w[3] = w3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  64'(fifo_rd_en),     64'd0);
    check({tag, "_valid"},  64'(m_valid),        64'd0);
    check({tag, "_last"},   64'(m_last),         64'd0);
    check({tag, "_busy"},   64'(busy),           64'd0);
    check({tag, "_data"},   64'(m_data),         64'd0);
    check({tag, "_done"},   64'(burst_done_cnt), 64'd0);
    check({tag, "_err_uf"}, 64'(err_underflow),  64'd0);
    check({tag, "_err_ab"}, 64'(err_abort),      64'd0);
  endtask

  initial begin
    int r0;
    int mg;
    logic [3:0]  lv;
    logic [11:0] lv12;

    set_vec(0, 8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    set_vec(1, 8'h10, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C);
    set_vec(2, 8'hF0, 32'hF3F2F1F0, 32'hF7F6F5F4, 32'hFBFAF9F8, 32'hFFFEFDFC);
    set_vec(3, 8'hA5, 32'hA8A7A6A5, 32'hACABAAA9, 32'hB0AFAEAD, 32'hB4B3B2B1);
    set_vec(4, 8'h7C, 32'h7F7E7D7C, 32'h83828180, 32'h87868584, 32'h8B8A8988);

    rst_n            = 1'b1;
    fifo_dout        = 8'h00;
    fifo_valid       = 1'b0;
    fifo_underflow   = 1'b0;
    fifo_rd_rst_busy = 1'b0;
    m_ready          = 1'b1;
    refresh();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single bursts with m_ready held high.
    for (int v = 0; v < 5; v++) begin
      got.delete();
      r0 = rd_total;
      push_bytes(vecs[v].base, 16);
      wait_words(4, 200);
      repeat (3) @(negedge clk);
      check("vec_reads", 64'(rd_total - r0), 64'd16);
      lv = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        check("vec_word", 64'(got[k][31:0]), 64'(vecs[v].w[k]));
        lv[k] = got[k][32];
      end
      check("vec_last", 64'(lv), 64'b1000);
      check("vec_done", 64'(burst_done_cnt), 64'(v + 1));
      check("vec_busy_idle", 64'(busy), 64'd0);
    end

    // 15 bytes never start a burst; the 16th does.
    got.delete();
    busy_seen = 1'b0;
    r0 = rd_total;
    push_bytes(8'h40, 15);
    repeat (100) @(negedge clk);
    check("partial_no_reads", 64'(rd_total - r0), 64'd0);
    check("partial_no_busy", 64'(busy_seen), 64'd0);
    push_bytes(8'h4F, 1);
    wait_words(4, 200);
    repeat (3) @(negedge clk);
    check("partial_reads", 64'(rd_total - r0), 64'd16);
    check("partial_w0", 64'(got[0]), {31'd0, 1'b0, 32'h43424140});
    check("partial_w3", 64'(got[3]), {31'd0, 1'b1, 32'h4F4E4D4C});
    check("partial_done", 64'(burst_done_cnt), 64'd6);

    // fifo_empty forced for 3 cycles mid-burst.
    got.delete();
    rd_idx_q.delete();
    r0 = rd_total;
    push_bytes(8'h00, 16);
    wait_reads(r0, 5, 50);
    force_empty = 1'b1;
    refresh();
    repeat (3) @(negedge clk);
    force_empty = 1'b0;
    refresh();
    wait_words(4, 200);
    repeat (3) @(negedge clk);
    mg = 0;
    for (int i = 1; i < rd_idx_q.size(); i++) begin
      if (rd_idx_q[i] - rd_idx_q[i-1] - 1 > mg) mg = rd_idx_q[i] - rd_idx_q[i-1] - 1;
    end
    check("stall_reads", 64'(rd_total - r0), 64'd16);
    check("stall_gap", 64'(mg), 64'd3);
    check("stall_w0", 64'(got[0]), {31'd0, 1'b0, 32'h03020100});
    check("stall_w1", 64'(got[1]), {31'd0, 1'b0, 32'h07060504});
    check("stall_w2", 64'(got[2]), {31'd0, 1'b0, 32'h0B0A0908});
    check("stall_w3", 64'(got[3]), {31'd0, 1'b1, 32'h0F0E0D0C});
    check("stall_errs", 64'({err_underflow, err_abort}), 64'd0);
    check("stall_done", 64'(burst_done_cnt), 64'd7);

    // Backpressure: two bursts fill the buffer, the third waits.
    m_ready = 1'b0;
    got.delete();
    r0 = rd_total;
    push_bytes(8'h00, 48);
    repeat (80) @(negedge clk);
    check("bp_reads", 64'(rd_total - r0), 64'd32);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_head", 64'(m_data), 64'h03020100);
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_fifo_left", 64'(fifo_rd_data_count), 64'd16);
    m_ready = 1'b1;
    wait_words(12, 400);
    repeat (3) @(negedge clk);
    lv12 = 12'd0;
    for (int k = 0; k < 12; k++) begin
      check("bp_word", 64'(got[k][31:0]), 64'(exp_word(8'h00, k)));
      lv12[k] = got[k][32];
    end
    check("bp_last", 64'(lv12), 64'b1000_1000_1000);
    check("bp_done", 64'(burst_done_cnt), 64'd10);

    // rd_rst_busy after 6 reads aborts the burst.
    got.delete();
    r0 = rd_total;
    push_bytes(8'h00, 16);
    wait_reads(r0, 6, 50);
    check("abort_rd_before", 64'(fifo_rd_en), 64'd1);
    fifo_rd_rst_busy = 1'b1;
    #1;
    check("abort_rd_gated", 64'(fifo_rd_en), 64'd0);
    @(negedge clk);
    fifo_rd_rst_busy = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_reads", 64'(rd_total - r0), 64'd6);
    check("abort_flag", 64'(err_abort), 64'd1);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_words", 64'(got.size()), 64'd1);
    check("abort_w0", 64'(got[0]), {31'd0, 1'b0, 32'h03020100});
    check("abort_done", 64'(burst_done_cnt), 64'd10);
    check("abort_no_uf", 64'(err_underflow), 64'd0);
    fq.delete();
    refresh();

    // Sticky underflow flag.
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    @(negedge clk);
    check("uf_set", 64'(err_underflow), 64'd1);
    repeat (5) @(negedge clk);
    check("uf_held", 64'(err_underflow), 64'd1);

    // Asynchronous reset mid-burst.
    r0 = rd_total;
    push_bytes(8'h00, 16);
    wait_reads(r0, 3, 50);
    check("midreset_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
